// File: rtl/dot_product_reader.sv
// dot_product_reader: streams addresses to two vector memories and multiply-accumulates their data into a dot product
module dot_product_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int ACC_WIDTH = 2*DATA_WIDTH+ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ACC_WIDTH-1:0]  result,
    output logic                  a_read_en,
    output logic [ADDR_WIDTH-1:0] a_read_address,
    input  logic [DATA_WIDTH-1:0] a_data,
    output logic                  b_read_en,
    output logic [ADDR_WIDTH-1:0] b_read_address,
    input  logic [DATA_WIDTH-1:0] b_data
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
    state_t state, state_next;
    logic accept, valid;
    logic [ADDR_WIDTH-1:0] last;
    logic [2*DATA_WIDTH-1:0] prod;
    logic [ACC_WIDTH-1:0] acc, acc_next;
    assign accept = start && (state == IDLE || state == DONE);
    assign prod = a_data * b_data;
    assign acc_next = valid ? acc + ACC_WIDTH'(prod) : acc;
    assign b_read_en = a_read_en;
    assign b_read_address = a_read_address;
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: state_next = accept ? (length == '0 ? DONE : READ) : IDLE;
            READ:       state_next = a_read_address == last ? DRAIN : READ;
            DRAIN:      state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            a_read_en      <= 1'b0;
            a_read_address <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            valid          <= 1'b0;
            last           <= '0;
            acc            <= '0;
            result         <= '0;
        end else begin
            state          <= state_next;
            a_read_en      <= state_next == READ;
            a_read_address <= (state == READ && state_next == READ) ? a_read_address + 1'b1 : '0;
            busy           <= state_next == READ || state_next == DRAIN;
            done           <= state_next == DONE;
            valid          <= a_read_en;
            if (accept) last <= length[ADDR_WIDTH] ? '1 : length[ADDR_WIDTH-1:0] - 1'b1;
            acc            <= accept ? '0 : acc_next;
            result         <= accept ? '0 : (state == DRAIN ? acc_next : result);
        end
    end
endmodule

// File: tb/tb_dot_product_reader.sv
// tb_dot_product_reader: directed runs against two 1-cycle-latency memory models
module tb_dot_product_reader;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int ACW = 2*DW+AW;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [AW:0] length = '0;
    logic busy, done, a_read_en, b_read_en;
    logic [ACW-1:0] result;
    logic [AW-1:0] a_read_address, b_read_address;
    logic [DW-1:0] a_data, b_data;
    logic [DW-1:0] mem_a [16];
    logic [DW-1:0] mem_b [16];
    int n_cmp = 0;
    int n_bad = 0;
    dot_product_reader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .length(length),
        .busy(busy), .done(done), .result(result),
        .a_read_en(a_read_en), .a_read_address(a_read_address), .a_data(a_data),
        .b_read_en(b_read_en), .b_read_address(b_read_address), .b_data(b_data)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (a_read_en) a_data <= mem_a[a_read_address];
        if (b_read_en) b_data <= mem_b[b_read_address];
    end
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic run(input string tag, input int len, input logic [ACW-1:0] exp,
                       input int n_reads, input bit mid);
        int k, reads, bad;
        bit seen;
        start = 1'b1;
        length = len[AW:0];
        @(negedge clk);
        start = 1'b0;
        k = 1;
        reads = 0;
        bad = 0;
        seen = 1'b0;
        while (k < 100 && !seen) begin
            if (a_read_en) begin
                if (a_read_address !== reads[AW-1:0]) bad++;
                reads++;
            end
            if (a_read_en !== b_read_en || a_read_address !== b_read_address) bad++;
            if (mid && k == 2) begin
                start = 1'b1;
                length = 5'd5;
            end
            if (mid && k == 3) start = 1'b0;
            if (done === 1'b1) seen = 1'b1;
            else begin
                k++;
                @(negedge clk);
            end
        end
        check({tag, "_done_cycle"}, 64'(k), 64'(n_reads == 0 ? 1 : n_reads + 2));
        check({tag, "_reads"}, 64'(reads), 64'(n_reads));
        check({tag, "_addr_seq"}, 64'(bad), 64'd0);
        check({tag, "_result"}, 64'(result), 64'(exp));
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    endtask
    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_read_en", 64'({a_read_en, b_read_en}), 64'd0);
        check("rst_addr", 64'({a_read_address, b_read_address}), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_read", 64'({a_read_en, busy, done}), 64'd0);
        mem_a[0] = 8'h11; mem_a[1] = 8'h22;
        mem_b[0] = 8'h02; mem_b[1] = 8'h03;
        run("run1", 2, 20'h88, 2, 1'b0);
        @(negedge clk);
        check("run1_done_pulse", 64'(done), 64'd0);
        check("run1_result_held", 64'(result), 64'h88);
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = 8'hFF;
            mem_b[i] = 8'hFF;
        end
        run("run2", 16, 20'hFE010, 16, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = 8'(i);
            mem_b[i] = 8'd1;
        end
        run("run3_zero", 0, 20'h0, 0, 1'b0);
        @(negedge clk);
        run("run3_clamp", 20, 20'h78, 16, 1'b0);
        @(negedge clk);
        run("run4_mid", 3, 20'h3, 3, 1'b1);
        run("run4_b2b", 2, 20'h1, 2, 1'b0);
        @(negedge clk);
        start = 1'b1;
        length = 5'd16;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("run5_reading", 64'({a_read_en, busy}), 64'b11);
        rst_n = 1'b0;
        #1;
        check("run5_async_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("run5_rst_busy", 64'(busy), 64'd0);
        check("run5_rst_read_en", 64'({a_read_en, b_read_en}), 64'd0);
        check("run5_rst_result", 64'(result), 64'd0);
        check("run5_rst_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("run5_no_done", 64'(done), 64'd0);
        run("run5_fresh", 4, 20'h6, 4, 1'b0);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
